if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch front end for the 5-stage RV32I pipeline.
- Owns the PC and drives a single-outstanding-request instruction memory handshake.
- Feeds the IF/ID pipeline register (pc, inst, valid) that the decode stage consumes.
- Accepts branch/jump redirects from decode (flag + target) and hold requests from pipeline control; flushes wrong-path fetches.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset
NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush/empty

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
stall_i  in  1  hold IF/ID and PC (from ctrl; excludes decode's own branch stallreq)
branch_flag_i  in  1  redirect request from decode, one-cycle pulse
branch_target_address_i  in  32  redirect target; bits [1:0] forced to 00
mem_req_o  in/out: out  1  fetch request
mem_addr_o  out  32  fetch address, stable while mem_req_o high and unacked
mem_ack_i  in  1  request accepted; mem_rdata_i valid same cycle
mem_rdata_i  in  32  fetched instruction
if_pc_o  out  32  IF/ID pc
if_inst_o  out  32  IF/ID instruction
if_valid_o  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=1 at edge): state=FETCH, pc=RESET_PC, req_addr=RESET_PC, buf invalid, if_pc_o=0, if_inst_o=NOP_INST, if_valid_o=0. mem_req_o is 0 during any cycle with rst=1. Reset mid-transaction abandons the outstanding request; a late ack is ignored.
- Handshake: transfer when mem_req_o && mem_ack_i. Ack may come in the same cycle as the request or any later cycle. The address must not change until ack.
- Minimum latency: request issued in cycle N, ack in N → instruction visible in IF/ID at N+1. Back-to-back, one instruction per cycle.
- mem_req_o=1 in FETCH and DROP, 0 in HOLD. mem_addr_o=req_addr.
- Priority: rst > branch_flag_i > stall_i.
- FETCH (req_addr=pc):
  - branch: pc<=target; IF/ID<=bubble (even if stall_i). If ack this cycle: discard rdata, stay FETCH, req_addr<=target. Else: → DROP, req_addr held.
  - ack, !stall: IF/ID<={pc,rdata,1}; pc<=pc+4; req_addr<=pc+4.
  - ack, stall: buf<={pc,rdata}; pc<=pc+4; req_addr<=pc+4; IF/ID held; → HOLD.
  - no ack: IF/ID<=bubble if !stall, else held.
- DROP: request outstanding to a stale address.
  - ack: discard; req_addr<=pc; → FETCH.
  - branch: pc<=target (latest wins), stay DROP.
  - IF/ID<=bubble if !stall.
- HOLD: one buffered instruction, no request.
  - branch: discard buf; pc<=target; req_addr<=target; IF/ID<=bubble; → FETCH.
  - !stall: IF/ID<=buf; → FETCH.
  - stall: stay, IF/ID held.
- Arithmetic: pc+4 wraps modulo 2^32 (0xFFFFFFFC → 0x00000000). Target low bits masked.
- Bubble = {pc unchanged, NOP_INST, valid=0}.

Decomposition:
- Shared defines header: RstEnable, ZeroWord, InstAddrBus/InstBus widths, NOP_INST value, FETCH/DROP/HOLD state encodings (2-bit).
- One natural sub-module: if_id_reg (IF/ID register with load/hold/flush controls), instantiated by if_fetch.
- PC/FSM logic stays in if_fetch.

Test Plan:
- Zero-wait stream: RESET_PC=0, ack held 1, rdata=addr^0xA5A50000 → IF/ID sees pc 0,4,8,… one per cycle, valid=1 from the cycle after rst deasserts.
- Variable latency: ack 3 cycles after each req → mem_addr_o stable through the wait, IF/ID bubbles (valid=0, inst=0x00000013) between instructions, pc increments only on ack.
- Redirect during wait: req to 0x10 unacked, branch to 0x200 → DROP; ack for 0x10 discarded; next req addr 0x200; first valid IF/ID pc=0x200.
- Stall on ack: stall_i=1 while 0x8 acked → HOLD, mem_req_o=0, IF/ID unchanged; stall release → IF/ID pc=0x8, then req 0xC.
- Branch in HOLD plus masking: buffered 0x8, branch target 0x103 → buffer dropped, req addr 0x100, IF/ID bubble.
- Wrap and reset: pc 0xFFFFFFFC acked → next req 0x0; assert rst with request outstanding → next req at RESET_PC, stale ack ignored.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, constants and fetch FSM encodings
package if_fetch_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam int          InstAddrBus  = 32;
    localparam int          InstBus      = 32;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [31:0] NopInstValue = 32'h0000_0013;
    localparam logic [31:0] PcStep       = 32'h0000_0004;
    localparam logic [31:0] AlignMask    = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_DROP  = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and bubble controls
module if_id_reg
    import if_fetch_pkg::*;
#(
    parameter logic [InstBus-1:0] NOP_INST = NopInstValue
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   flush_i,
    input  logic [InstAddrBus-1:0] pc_i,
    input  logic [InstBus-1:0]     inst_i,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
    output logic                   valid_o
);

    logic [InstAddrBus-1:0] pc_q;
    logic [InstBus-1:0]     inst_q;
    logic                   valid_q;

    // Bubble keeps the pc field, swaps in a NOP; flush wins over load; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc_q    <= ZeroWord;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            inst_q  <= inst_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch front end: PC, imem handshake, redirect and hold
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [InstBus-1:0]     NOP_INST = NopInstValue
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_target_address_i,
    output logic                   mem_req_o,
    output logic [InstAddrBus-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [InstBus-1:0]     mem_rdata_i,
    output logic [InstAddrBus-1:0] if_pc_o,
    output logic [InstBus-1:0]     if_inst_o,
    output logic                   if_valid_o
);

    fetch_state_e           state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstAddrBus-1:0] req_addr_q, req_addr_d;
    logic [InstAddrBus-1:0] buf_pc_q, buf_pc_d;
    logic [InstBus-1:0]     buf_inst_q, buf_inst_d;

    logic                   ifid_load, ifid_flush;
    logic [InstAddrBus-1:0] ifid_pc;
    logic [InstBus-1:0]     ifid_inst;
    logic                   xfer;
    logic [InstAddrBus-1:0] target;
    logic [InstAddrBus-1:0] pc_next_seq;

    assign mem_req_o   = (rst != RstEnable) && (state_q != ST_HOLD);
    assign mem_addr_o  = req_addr_q;
    assign xfer        = mem_req_o && mem_ack_i;
    assign target      = branch_target_address_i & AlignMask;
    assign pc_next_seq = pc_q + PcStep;

    // State, PC, request address and hold buffer registers.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            buf_pc_q   <= ZeroWord;
            buf_inst_q <= NOP_INST;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    // Next-state and IF/ID control: redirect beats stall; a stale in-flight request goes through DROP.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_pc    = pc_q;
        ifid_inst  = mem_rdata_i;
        case (state_q)
            ST_FETCH: begin
                if (branch_flag_i) begin
                    pc_d       = target;
                    ifid_flush = 1'b1;
                    if (xfer) begin
                        req_addr_d = target;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else if (xfer) begin
                    pc_d       = pc_next_seq;
                    req_addr_d = pc_next_seq;
                    if (!stall_i) begin
                        ifid_load = 1'b1;
                    end else begin
                        buf_pc_d   = pc_q;
                        buf_inst_d = mem_rdata_i;
                        state_d    = ST_HOLD;
                    end
                end else if (!stall_i) begin
                    ifid_flush = 1'b1;
                end
            end
            ST_DROP: begin
                if (branch_flag_i) begin
                    pc_d = target;
                end
                if (xfer) begin
                    req_addr_d = pc_d;
                    state_d    = ST_FETCH;
                end
                if (!stall_i) begin
                    ifid_flush = 1'b1;
                end
            end
            ST_HOLD: begin
                if (branch_flag_i) begin
                    pc_d       = target;
                    req_addr_d = target;
                    ifid_flush = 1'b1;
                    state_d    = ST_FETCH;
                end else if (!stall_i) begin
                    ifid_load = 1'b1;
                    ifid_pc   = buf_pc_q;
                    ifid_inst = buf_inst_q;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .pc_i    (ifid_pc),
        .inst_i  (ifid_inst),
        .pc_o    (if_pc_o),
        .inst_o  (if_inst_o),
        .valid_o (if_valid_o)
    );

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr ^ KEY;

    if_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall_i                 (stall),
        .branch_flag_i           (branch),
        .branch_target_address_i (target),
        .mem_req_o               (mem_req),
        .mem_addr_o              (mem_addr),
        .mem_ack_i               (mem_ack),
        .mem_rdata_i             (mem_rdata),
        .if_pc_o                 (if_pc),
        .if_inst_o               (if_inst),
        .if_valid_o              (if_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'h0; mem_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'h0; mem_ack = 1'b1;
        step();
        step();
        total_cnt++; if (if_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", if_valid); else pass_cnt++;
        total_cnt++; if (if_inst !== NOP) $display("FAIL reset_inst got %h want %h", if_inst, NOP); else pass_cnt++;
        total_cnt++; if (if_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", if_pc); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL reset_req got %0b want 0", mem_req); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", mem_addr); else pass_cnt++;
    endtask

    task automatic test_zero_wait();
        do_reset();
        mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total_cnt++; if (if_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %0b want 1", i, if_valid); else pass_cnt++;
            total_cnt++; if (if_pc !== 32'(4 * i)) $display("FAIL stream_pc[%0d] got %h want %h", i, if_pc, 32'(4 * i)); else pass_cnt++;
            total_cnt++; if (if_inst !== (32'(4 * i) ^ KEY)) $display("FAIL stream_inst[%0d] got %h want %h", i, if_inst, 32'(4 * i) ^ KEY); else pass_cnt++;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_variable_latency();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            mem_ack = 1'b0;
            for (int w = 0; w < 3; w++) begin
                total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * k)) $display("FAIL lat_addr[%0d.%0d] got req=%0b addr=%h want req=1 addr=%h", k, w, mem_req, mem_addr, 32'(4 * k)); else pass_cnt++;
                step();
                total_cnt++; if (if_valid !== 1'b0 || if_inst !== NOP) $display("FAIL lat_bubble[%0d.%0d] got v=%0b inst=%h want v=0 inst=%h", k, w, if_valid, if_inst, NOP); else pass_cnt++;
            end
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            total_cnt++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * k)) $display("FAIL lat_inst[%0d] got v=%0b pc=%h want v=1 pc=%h", k, if_valid, if_pc, 32'(4 * k)); else pass_cnt++;
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        mem_ack = 1'b1;
        repeat (4) step();
        mem_ack = 1'b0;
        step();
        total_cnt++; if (mem_addr !== 32'h10) $display("FAIL drop_pre_addr got %h want 00000010", mem_addr); else pass_cnt++;
        branch = 1'b1; target = 32'h200;
        step();
        branch = 1'b0;
        total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) $display("FAIL drop_hold_addr got req=%0b addr=%h want req=1 addr=00000010", mem_req, mem_addr); else pass_cnt++;
        total_cnt++; if (if_valid !== 1'b0) $display("FAIL drop_bubble got %0b want 0", if_valid); else pass_cnt++;
        mem_ack = 1'b1;
        step();
        total_cnt++; if (mem_addr !== 32'h200) $display("FAIL drop_new_addr got %h want 00000200", mem_addr); else pass_cnt++;
        total_cnt++; if (if_valid !== 1'b0) $display("FAIL drop_discard got %0b want 0", if_valid); else pass_cnt++;
        step();
        mem_ack = 1'b0;
        total_cnt++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_inst !== (32'h200 ^ KEY)) $display("FAIL drop_first got v=%0b pc=%h inst=%h want v=1 pc=00000200 inst=%h", if_valid, if_pc, if_inst, 32'h200 ^ KEY); else pass_cnt++;
    endtask

    task automatic test_stall_hold();
        do_reset();
        mem_ack = 1'b1;
        repeat (2) step();
        stall = 1'b1;
        step();
        mem_ack = 1'b0;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL hold_req got %0b want 0", mem_req); else pass_cnt++;
        total_cnt++; if (if_valid !== 1'b1 || if_pc !== 32'h4) $display("FAIL hold_ifid got v=%0b pc=%h want v=1 pc=00000004", if_valid, if_pc); else pass_cnt++;
        step();
        total_cnt++; if (mem_req !== 1'b0 || if_pc !== 32'h4) $display("FAIL hold_stay got req=%0b pc=%h want req=0 pc=00000004", mem_req, if_pc); else pass_cnt++;
        stall = 1'b0;
        step();
        total_cnt++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== (32'h8 ^ KEY)) $display("FAIL hold_release got v=%0b pc=%h inst=%h want v=1 pc=00000008 inst=%h", if_valid, if_pc, if_inst, 32'h8 ^ KEY); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'hC) $display("FAIL hold_next_req got req=%0b addr=%h want req=1 addr=0000000c", mem_req, mem_addr); else pass_cnt++;
    endtask

    task automatic test_branch_hold();
        do_reset();
        mem_ack = 1'b1;
        repeat (2) step();
        stall = 1'b1;
        step();
        mem_ack = 1'b0;
        branch = 1'b1; target = 32'h103;
        step();
        branch = 1'b0; stall = 1'b0;
        total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) $display("FAIL bhold_addr got req=%0b addr=%h want req=1 addr=00000100", mem_req, mem_addr); else pass_cnt++;
        total_cnt++; if (if_valid !== 1'b0 || if_inst !== NOP || if_pc !== 32'h4) $display("FAIL bhold_bubble got v=%0b inst=%h pc=%h want v=0 inst=%h pc=00000004", if_valid, if_inst, if_pc, NOP); else pass_cnt++;
    endtask

    task automatic test_wrap_reset();
        do_reset();
        mem_ack = 1'b1; branch = 1'b1; target = 32'hFFFF_FFFF;
        step();
        branch = 1'b0;
        total_cnt++; if (mem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_target got %h want fffffffc", mem_addr); else pass_cnt++;
        total_cnt++; if (if_valid !== 1'b0) $display("FAIL wrap_branch_bubble got %0b want 0", if_valid); else pass_cnt++;
        step();
        total_cnt++; if (if_pc !== 32'hFFFF_FFFC || if_valid !== 1'b1) $display("FAIL wrap_last got v=%0b pc=%h want v=1 pc=fffffffc", if_valid, if_pc); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h0) $display("FAIL wrap_next got %h want 00000000", mem_addr); else pass_cnt++;
        repeat (2) step();
        mem_ack = 1'b0;
        step();
        total_cnt++; if (mem_addr !== 32'h8 || mem_req !== 1'b1) $display("FAIL wrap_pending got req=%0b addr=%h want req=1 addr=00000008", mem_req, mem_addr); else pass_cnt++;
        rst = 1'b1; mem_ack = 1'b1;
        #1;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL rst_req_low got %0b want 0", mem_req); else pass_cnt++;
        step();
        rst = 1'b0; mem_ack = 1'b0;
        #1;
        total_cnt++; if (if_valid !== 1'b0 || if_inst !== NOP) $display("FAIL rst_stale_ack got v=%0b inst=%h want v=0 inst=%h", if_valid, if_inst, NOP); else pass_cnt++;
        total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) $display("FAIL rst_restart got req=%0b addr=%h want req=1 addr=00000000", mem_req, mem_addr); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_variable_latency();
        test_redirect_drop();
        test_stall_hold();
        test_branch_hold();
        test_wrap_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
